// File: rtl/caf_axis_player.sv
// AXI4-Stream sample player: an on-chip buffer, loaded through a write port, is replayed
// as a framed stream, either once or looped until a stop is requested.
module caf_axis_player #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int FCOUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    n_reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [ADDR_WIDTH:0]     length,
    input  logic                    loop,
    input  logic                    start,
    input  logic                    stop,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic                    busy,
    output logic                    done,
    output logic [FCOUNT_WIDTH-1:0] frame_count
);
    localparam int DEPTH = 2**ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [ADDR_WIDTH-1:0] idx, idx_nx, rd_addr, last_q, eff_last;
    logic                  loop_q, stop_pending;
    logic                  start_ok, hs, at_last, finish;

    // Any length >= DEPTH has bit ADDR_WIDTH set and clamps to the full buffer.
    assign eff_last = length[ADDR_WIDTH] ? '1 : length[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
    assign start_ok = (state == IDLE) && start && (length != '0);
    assign hs       = (state == PLAY) && m_axis_tready;
    assign at_last  = (idx == last_q);
    assign idx_nx   = at_last ? '0 : idx + ADDR_WIDTH'(1);
    assign finish   = hs && ((at_last && !loop_q) || stop_pending);
    // Read one beat ahead on a handshake so the next sample is ready without a bubble.
    assign rd_addr  = hs ? idx_nx : idx;

    always_ff @(posedge clk) begin
        if (wr_en && state == IDLE)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx      = state;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        busy          = (state != IDLE);
        case (state)
            IDLE:  if (start_ok) state_nx = FETCH;
            FETCH: state_nx = PLAY;
            PLAY: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = at_last;
                m_axis_tdata  = rd_q;
                if (finish) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            idx          <= '0;
            last_q       <= '0;
            loop_q       <= 1'b0;
            stop_pending <= 1'b0;
            frame_count  <= '0;
            done         <= 1'b0;
        end else begin
            done <= finish;
            if (start_ok) begin
                idx          <= '0;
                last_q       <= eff_last;
                loop_q       <= loop;
                stop_pending <= 1'b0;
                frame_count  <= '0;
            end else begin
                // A stop sampled with a handshake takes effect on the following one.
                if (stop && state != IDLE) stop_pending <= 1'b1;
                if (hs) begin
                    idx <= idx_nx;
                    if (at_last && frame_count != '1)
                        frame_count <= frame_count + FCOUNT_WIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_caf_axis_player.sv
// Randomized bench for caf_axis_player: beats are captured by a monitor and compared with
// a sequence derived from a buffer model and the playback rules (length clamp, loop, stop).
module tb_caf_axis_player;
    localparam int DW = 32, AW = 4, FW = 16, DEPTH = 16;

    logic          clk = 1'b0, n_reset = 1'b0, wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW:0]   length = '0;
    logic          loop = 1'b0, start = 1'b0, stop = 1'b0, m_axis_tready = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast, busy, done;
    logic [FW-1:0] frame_count;

    int checks = 0, errors = 0;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] got_d[$], exp_d[$];
    logic          got_l[$], exp_l[$];
    int first_v, done_n, stop_k;

    caf_axis_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FCOUNT_WIDTH(FW)) dut (
        .clk(clk), .n_reset(n_reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .length(length), .loop(loop), .start(start), .stop(stop),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .done(done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic wr(input int a, input logic [DW-1:0] d);
        wr_en = 1'b1; wr_addr = a[AW-1:0]; wr_data = d; model[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // Expected stream: beat j carries buf[j mod L], tlast when j mod L == L-1.
    function automatic void build_exp(input int len, input int n);
        int L;
        L = (len > DEPTH) ? DEPTH : len;
        exp_d.delete(); exp_l.delete();
        for (int j = 0; j < n; j++) begin
            exp_d.push_back(model[j % L]);
            exp_l.push_back((j % L) == L - 1);
        end
    endfunction

    // Pulse start, then run cycles with random tready until done or the budget expires.
    task automatic collect(input int len, input bit lp, input int rdy_pct, input int stop_at,
                           input int budget, input bit hazard);
        logic [DW-1:0] pd;
        logic pl, pv, pr;
        bit stop_sent, finished;
        int hs_n;
        got_d.delete(); got_l.delete();
        first_v = -1; done_n = 0; stop_k = -1; hs_n = 0;
        stop_sent = 0; finished = 0; pv = 0; pr = 0; pd = '0; pl = 0;
        start = 1'b1; length = len[AW:0]; loop = lp;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            if (cyc > 0) start = 1'b0;
            m_axis_tready = ($urandom_range(99) < rdy_pct);
            stop = 1'b0;
            if (!stop_sent && stop_at >= 0 && m_axis_tvalid === 1'b1 && hs_n == stop_at) begin
                stop = 1'b1; stop_sent = 1;
            end
            wr_en = 1'b0;
            if (hazard && cyc == 4) begin wr_en = 1'b1; wr_addr = 1; wr_data = ~model[1]; end
            if (hazard && cyc == 6) begin start = 1'b1; length = 2; loop = 1'b0; end
            @(negedge clk);
            if (done === 1'b1) begin
                done_n++; finished = 1;
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL busy_at_done got %b exp 0", busy); end
            end
            if (m_axis_tvalid === 1'b1 && first_v < 0) first_v = cyc;
            if (pv && !pr) begin
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== pd || m_axis_tlast !== pl) begin
                    errors++;
                    $display("FAIL stall_hold cyc %0d got v%b d%h l%b exp v1 d%h l%b",
                             cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, pd, pl);
                end
            end
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                got_d.push_back(m_axis_tdata); got_l.push_back(m_axis_tlast); hs_n++;
            end
            if (stop) stop_k = hs_n;
            pv = (m_axis_tvalid === 1'b1); pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
            @(posedge clk); #1;
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0; m_axis_tready = 1'b0;
    endtask

    task automatic test_reset;
        n_reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0 || m_axis_tdata !== '0 || frame_count !== '0) begin
            errors++;
            $display("FAIL reset got v%b l%b b%b d%b data %h fc %0d exp all 0",
                     m_axis_tvalid, m_axis_tlast, busy, done, m_axis_tdata, frame_count);
        end
        @(posedge clk); #1;
        n_reset = 1'b1;
    endtask

    task automatic test_one_shot;
        for (int i = 0; i < 4; i++) wr(i, 32'hA0 + i);
        collect(4, 0, 100, -1, 20, 0);
        build_exp(4, 4);
        checks++;
        if (first_v !== 2) begin errors++; $display("FAIL oneshot_latency got %0d exp 2", first_v); end
        checks++;
        if (got_d.size() != 4) begin errors++; $display("FAIL oneshot_count got %0d exp 4", got_d.size()); end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL oneshot_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        checks++;
        if (done_n !== 1 || frame_count !== 16'd1) begin
            errors++; $display("FAIL oneshot_done got done %0d fc %0d exp 1 1", done_n, frame_count);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            errors++; $display("FAIL oneshot_after got done %b v %b exp 0 0", done, m_axis_tvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < DEPTH; i++) wr(i, $urandom);
        for (int it = 0; it < 4; it++) begin
            int len;
            len = (it == 0) ? 4 : $urandom_range(16, 1);
            collect(len, 0, $urandom_range(70, 30), -1, 400, 0);
            build_exp(len, len);
            checks++;
            if (got_d.size() != len || done_n != 1 || frame_count !== FW'(1)) begin
                errors++;
                $display("FAIL bp_count it%0d got %0d beats done %0d fc %0d exp %0d 1 1",
                         it, got_d.size(), done_n, frame_count, len);
            end
            for (int i = 0; i < got_d.size() && i < len; i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL bp_beat it%0d i%0d got %h/%b exp %h/%b", it, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_loop_stop;
        for (int it = 0; it < 3; it++) begin
            int len, n, rdy, sa;
            len = (it == 0) ? 3 : $urandom_range(6, 1);
            rdy = (it == 0) ? 100 : 60;
            sa  = (it == 0) ? 7 : $urandom_range(15, 2);
            collect(len, 1, rdy, sa, 400, 0);
            n = stop_k + 1;
            build_exp(len, n);
            checks++;
            if (got_d.size() != n || done_n != 1 || frame_count !== FW'(n / len)) begin
                errors++;
                $display("FAIL loop_count it%0d got %0d beats done %0d fc %0d exp %0d 1 %0d",
                         it, got_d.size(), done_n, frame_count, n, n / len);
            end
            for (int i = 0; i < got_d.size() && i < n; i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                    errors++;
                    $display("FAIL loop_beat it%0d i%0d got %h/%b exp %h/%b", it, i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_length_bounds;
        collect(0, 0, 100, -1, 10, 0);
        checks++;
        if (got_d.size() != 0 || first_v != -1 || done_n != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0 got beats %0d first_v %0d done %0d busy %b exp 0 -1 0 0",
                     got_d.size(), first_v, done_n, busy);
        end
        collect(DEPTH + 5, 0, 100, -1, 60, 0);
        build_exp(DEPTH + 5, DEPTH);
        checks++;
        if (got_d.size() != DEPTH || done_n != 1) begin
            errors++; $display("FAIL len_clamp got %0d beats done %0d exp 16 1", got_d.size(), done_n);
        end
        for (int i = 0; i < got_d.size() && i < DEPTH; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL len_clamp_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        collect(1, 1, 100, 4, 60, 0);
        build_exp(1, 6);
        checks++;
        if (got_d.size() != 6 || frame_count !== 16'd6) begin
            errors++; $display("FAIL len1 got %0d beats fc %0d exp 6 6", got_d.size(), frame_count);
        end
        for (int i = 0; i < got_d.size() && i < 6; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== 1'b1) begin
                errors++; $display("FAIL len1_beat%0d got %h/%b exp %h/1", i, got_d[i], got_l[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_hazards;
        // Write and restart during playback must not disturb the looped stream.
        collect(5, 1, 100, 12, 60, 1);
        build_exp(5, 14);
        checks++;
        if (got_d.size() != 14 || done_n != 1) begin
            errors++; $display("FAIL hazard_count got %0d beats done %0d exp 14 1", got_d.size(), done_n);
        end
        for (int i = 0; i < got_d.size() && i < 14; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                errors++;
                $display("FAIL hazard_beat%0d got %h/%b exp %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]);
            end
        end
        // Reset mid-frame.
        start = 1'b1; length = 2; loop = 1'b1; m_axis_tready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        n_reset = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, busy, done} !== 4'b0 || m_axis_tdata !== '0 || frame_count !== '0) begin
            errors++;
            $display("FAIL midreset got v%b l%b b%b d%b data %h fc %0d exp all 0",
                     m_axis_tvalid, m_axis_tlast, busy, done, m_axis_tdata, frame_count);
        end
        @(posedge clk); #1;
        n_reset = 1'b1; m_axis_tready = 1'b0;
        collect(4, 0, 100, -1, 20, 0);
        build_exp(4, 4);
        checks++;
        if (got_d.size() != 4 || done_n != 1) begin
            errors++; $display("FAIL replay_count got %0d done %0d exp 4 1", got_d.size(), done_n);
        end
        for (int i = 0; i < got_d.size() && i < 4; i++) begin
            checks++;
            if (got_d[i] !== exp_d[i]) begin
                errors++; $display("FAIL replay_beat%0d got %h exp %h", i, got_d[i], exp_d[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_backpressure();
        test_loop_stop();
        test_length_bounds();
        test_hazards();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
